serial_word_comparator: RTL and testbench
=========================================

Name: serial_word_comparator

Overview:
Sequential WIDTH-bit magnitude comparator built from the one-bit compare cell, applied one bit per clock, MSB first.
- Operands are accepted on a valid/ready request port.
- The unsigned lt/gt/eq verdict is returned on a valid/ready result port.
- Used where a wide parallel comparator costs too much area and multi-cycle latency is acceptable.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset; asynchronous and active-low (already decided)
req_valid  input  1  operands a_in/b_in valid
req_ready  output  1  block can accept operands
a_in  input  WIDTH  operand A, unsigned
b_in  input  WIDTH  operand B, unsigned
res_valid  output  1  lt/gt/eq hold a valid verdict
res_ready  input  1  consumer accepts verdict
lt  output  1  A < B
gt  output  1  A > B
eq  output  1  A == B
busy  output  1  high in SCAN or DONE

Behaviour:
Reset:
- rst_n low asynchronously forces state=IDLE, idx=0, operand registers=0.
- Outputs under reset: req_ready=1, res_valid=0, lt=gt=eq=0, busy=0.
- Reset mid-SCAN or mid-DONE aborts the operation with no result.

States:
- IDLE: req_ready=1. On an edge with req_valid&req_ready: capture a_in/b_in, set idx=WIDTH-1, clear the internal diff flag, go to SCAN.
- SCAN: each cycle apply the 1-bit cell to A[idx], B[idx]:
  - Cell lt = ~a&b, gt = a&~b.
  - On the first cycle where lt|gt=1, latch lt/gt into the verdict registers and set diff; later bits are ignored.
  - idx decrements by 1 per cycle.
  - Exit to DONE when idx==0 is processed (or earlier, see Optional Feature).
- DONE: res_valid=1.
  - lt/gt/eq are registered and stable for as long as res_valid is high.
  - eq=1 iff no differing bit was found. Exactly one of lt/gt/eq is 1.
  - On an edge with res_valid&res_ready: go to IDLE, clear lt/gt/eq to 0.

Handshake rules:
- req_ready=1 only in IDLE. req_valid is ignored in SCAN and DONE; no request queuing.
- res_valid, once high, does not drop until the handshake completes.
- res_ready is ignored outside DONE.
- Back-to-back operation: the result handshake edge returns to IDLE. The next request is accepted no earlier than the following edge, so the minimum issue interval is latency+2 cycles.

Latency:
- Count edges after the accept edge E0. Without early exit, res_valid rises after edge E0+WIDTH.
- busy=1 from after E0 until the result handshake edge.

Width and arithmetic:
- Comparison is unsigned only.
- idx is CNT_W bits and never wraps below 0; the block leaves SCAN after idx==0.

Optional Feature:
Macro: SERIAL_CMP_EARLY_EXIT_EN
- Defined: SCAN goes to DONE on the same edge that processes the first differing bit.
  - Latency is variable: a difference at bit k gives res_valid after edge E0+(WIDTH-k).
  - Equal operands still take WIDTH cycles.
- Undefined: latency is always WIDTH cycles regardless of data.
  - Bits after the first difference are scanned but do not change the verdict.

Test Plan (WIDTH=8):
1. Equal operands: a_in=0xA5, b_in=0xA5 -> res_valid after E0+8; eq=1, lt=0, gt=0. Same timing with or without the macro.
2. MSB difference: a_in=0x80, b_in=0x7F -> gt=1. res_valid after E0+1 with SERIAL_CMP_EARLY_EXIT_EN, after E0+8 without it.
3. LSB difference: a_in=0x00, b_in=0x01 -> lt=1, res_valid after E0+8 in both builds. Then a_in=0xFF, b_in=0xFE -> gt=1.
4. Backpressure: hold res_ready=0 for 5 cycles in DONE while driving req_valid=1 with new operands -> lt/gt/eq and res_valid stable, req_ready=0, new operands not captured. Raise res_ready -> IDLE on that edge, outputs cleared.
5. Reset mid-scan: accept a_in=0x3C, b_in=0x3D, assert rst_n=0 after 3 cycles, asynchronously -> outputs immediately at reset values. After release, a new request completes normally with a correct verdict.
6. Back-to-back: three requests (0x10 vs 0x20, 0x20 vs 0x10, 0x55 vs 0x55) with res_ready tied 1 and req_valid held -> verdicts lt, gt, eq in order. No request dropped or duplicated; accept spacing is latency+2 cycles.

Source files
------------

// File: rtl/serial_word_comparator.sv
// serial_word_comparator
//   Unsigned WIDTH-bit magnitude comparator that scans one bit per clock,
//   MSB first, using a single 1-bit compare cell. Operands arrive on a
//   valid/ready request port. The lt/gt/eq verdict leaves on a valid/ready
//   result port.
//
//   Build option: define SERIAL_CMP_EARLY_EXIT_EN to finish the scan on the
//   first differing bit. Without it, every compare takes WIDTH cycles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  a_in/b_in valid
//   req_ready  block can accept operands (IDLE only)
//   a_in,b_in  unsigned operands
//   res_valid  verdict valid (DONE)
//   res_ready  consumer accepts verdict
//   lt,gt,eq   registered verdict, exactly one set while res_valid
//   busy       operation in flight (SCAN or DONE)
//
// state | meaning
// IDLE  | waiting for operands, req_ready=1
// SCAN  | comparing bit idx each cycle, MSB first
// DONE  | verdict held on lt/gt/eq until result handshake
module serial_word_comparator #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             diff_q;
    logic             lt_q, gt_q, eq_q;

    logic             cell_lt, cell_gt, cell_diff;

    // Single 1-bit compare cell on the current bit.
    assign cell_lt   = ~a_q[idx_q] &  b_q[idx_q];
    assign cell_gt   =  a_q[idx_q] & ~b_q[idx_q];
    assign cell_diff = cell_lt | cell_gt;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) state_nxt = SCAN;
            end
            SCAN: begin
                if (idx_q == '0) state_nxt = DONE;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                // diff_q can never be set here: the first difference exits.
                if (cell_diff) state_nxt = DONE;
`endif
            end
            DONE: begin
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= 1'b0;
            lt_q   <= 1'b0;
            gt_q   <= 1'b0;
            eq_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        a_q    <= a_in;
                        b_q    <= b_in;
                        idx_q  <= CNT_W'(WIDTH - 1);
                        diff_q <= 1'b0;
                        lt_q   <= 1'b0;
                        gt_q   <= 1'b0;
                        eq_q   <= 1'b0;
                    end
                end
                SCAN: begin
                    // Only the first differing bit decides the verdict.
                    if (!diff_q && cell_diff) begin
                        diff_q <= 1'b1;
                        lt_q   <= cell_lt;
                        gt_q   <= cell_gt;
                    end
                    if (idx_q != '0) idx_q <= idx_q - 1'b1;
                    if (state_nxt == DONE) eq_q <= ~(diff_q | cell_diff);
                end
                DONE: begin
                    if (res_ready) begin
                        lt_q <= 1'b0;
                        gt_q <= 1'b0;
                        eq_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign lt        = lt_q;
    assign gt        = gt_q;
    assign eq        = eq_q;

endmodule

// File: tb/tb_serial_word_comparator.sv
module tb_serial_word_comparator;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         res_ready = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         req_ready, res_valid, lt, gt, eq, busy;

    int n_cmp = 0;
    int n_err = 0;

    serial_word_comparator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .lt        (lt),
        .gt        (gt),
        .eq        (eq),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: verdict from plain unsigned arithmetic, latency from
    // the position of the most significant differing bit.
    function automatic logic [2:0] ref_verdict(input logic [W-1:0] a, input logic [W-1:0] b);
        return {a < b, a > b, a == b};
    endfunction

    function automatic int ref_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int k = W - 1; k >= 0; k--)
            if (a[k] != b[k]) return W - k;
`endif
        return W;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle-state snapshot: {res_valid, lt, gt, eq, busy, req_ready}
    function automatic logic [5:0] idle_vec();
        return {res_valid, lt, gt, eq, busy, req_ready};
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input string tag);
        int lat;
        logic [2:0] v;
        check({tag, "_req_ready"}, req_ready, 1'b1);
        a_in = a;
        b_in = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        lat = 0;
        while (lat < 4 * W) begin
            tick();
            lat++;
            if (res_valid) break;
        end
        check({tag, "_latency"}, lat, ref_latency(a, b));
        v = ref_verdict(a, b);
        check({tag, "_verdict"}, {lt, gt, eq}, v);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            a_in = ~a;
            b_in = a;
            tick();
            check({tag, "_hold_valid"}, res_valid, 1'b1);
            check({tag, "_hold_verdict"}, {lt, gt, eq}, v);
            check({tag, "_hold_req_ready"}, req_ready, 1'b0);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, "_after_hs"}, idle_vec(), 6'b000001);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [W-1:0] ba [3];
        logic [W-1:0] bb [3];
        logic [2:0]   got_v [$];
        int           acc [3];
        int           n_acc;
        int           cyc;
        logic         acc_now;

        #1;
        check("reset_outputs", idle_vec(), 6'b000001);
        #11 rst_n = 1'b1;
        tick();
        check("post_reset_idle", idle_vec(), 6'b000001);

        run_op(8'hA5, 8'hA5, 0, "equal");
        run_op(8'h80, 8'h7F, 0, "msb_diff");
        run_op(8'h00, 8'h01, 0, "lsb_lt");
        run_op(8'hFF, 8'hFE, 0, "lsb_gt");
        run_op(8'h12, 8'h34, 5, "backpressure");

        // Reset in the middle of a scan.
        a_in = 8'h3C;
        b_in = 8'h3D;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_scan_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", idle_vec(), 6'b000001);
        #3 rst_n = 1'b1;
        tick();
        check("reset_release_idle", idle_vec(), 6'b000001);
        run_op(8'h3C, 8'h3D, 0, "after_reset");

        // Back-to-back with req_valid held and res_ready tied high.
        ba[0] = 8'h10; bb[0] = 8'h20;
        ba[1] = 8'h20; bb[1] = 8'h10;
        ba[2] = 8'h55; bb[2] = 8'h55;
        n_acc = 0;
        res_ready = 1'b1;
        a_in = ba[0];
        b_in = bb[0];
        req_valid = 1'b1;
        for (cyc = 0; cyc < 200 && got_v.size() < 3; cyc++) begin
            acc_now = 1'b0;
            if (req_valid && req_ready) begin
                if (n_acc < 3) acc[n_acc] = cyc;
                n_acc++;
                acc_now = 1'b1;
            end
            if (res_valid && res_ready) got_v.push_back({lt, gt, eq});
            tick();
            if (acc_now) begin
                if (n_acc < 3) begin
                    a_in = ba[n_acc];
                    b_in = bb[n_acc];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        res_ready = 1'b0;
        check("b2b_accepts", n_acc, 3);
        check("b2b_results", got_v.size(), 3);
        if (got_v.size() == 3 && n_acc == 3) begin
            for (int i = 0; i < 3; i++)
                check("b2b_verdict", got_v[i], ref_verdict(ba[i], bb[i]));
            for (int i = 0; i < 2; i++)
                check("b2b_spacing", acc[i+1] - acc[i], ref_latency(ba[i], bb[i]) + 2);
        end
        tick();
        check("b2b_idle", idle_vec(), 6'b000001);

        // Randomized operands: random, equal, and single-bit differences.
        for (int t = 0; t < 30; t++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = W'($urandom);
                1:       rb = ra;
                default: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
            endcase
            run_op(ra, rb, $urandom_range(0, 3), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
